phy_tx_framer: RTL

- Parametrised PCIe-style transmit framer: the synthesizable successor to the fixed-pattern PHY stimulus generator.
- Accepts packet beats over a valid/ready interface and emits a multi-lane symbol stream with a K-flag per lane.
- Inserts STP/SDP start and END/EDB end framing, fills with IDL when idle, and periodically inserts a COM+SKP ordered set between packets.
- Sits between the link layer and the PHY lane serializers.

---
 rtl/phy_symbols_pkg.sv | 26 ++
 rtl/phy_skp_timer.sv | 35 +++
 rtl/phy_tx_framer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/phy_symbols_pkg.sv
// Shared definitions for the PHY transmit framer.
//   - 8-bit lane symbol codes (K-characters for control beats)
//   - framer FSM state encoding
package phy_symbols_pkg;

    localparam int unsigned SYM_W = 8;

    localparam logic [SYM_W-1:0] SYM_STP = 8'hFB;
    localparam logic [SYM_W-1:0] SYM_SDP = 8'h5C;
    localparam logic [SYM_W-1:0] SYM_END = 8'hFD;
    localparam logic [SYM_W-1:0] SYM_EDB = 8'hFE;
    localparam logic [SYM_W-1:0] SYM_SKP = 8'h1C;
    localparam logic [SYM_W-1:0] SYM_IDL = 8'h7C;
    localparam logic [SYM_W-1:0] SYM_FTS = 8'h3C;
    localparam logic [SYM_W-1:0] SYM_COM = 8'hBC;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_END     = 3'd3,
        ST_SKP_COM = 3'd4,
        ST_SKP     = 3'd5
    } framer_state_e;

endpackage

// File: rtl/phy_skp_timer.sv
// Saturating beat counter that flags when a skip ordered set is due.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   en          - count one beat
//   clr         - restart the interval (wins over en)
//   skip_due    - counter has reached SKP_INTERVAL
module phy_skp_timer #(
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic skip_due
);

    localparam int unsigned CW = $clog2(SKP_INTERVAL + 1);
    localparam logic [CW-1:0] LIMIT = CW'(SKP_INTERVAL);

    logic [CW-1:0] count;

    // Count up to LIMIT and hold there until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

    assign skip_due = (count == LIMIT);

endmodule

// File: rtl/phy_tx_framer.sv
// Multi-lane transmit framer: wraps link-layer packets in STP/SDP ... END/EDB,
// fills idle time with IDL and inserts COM+SKP ordered sets between packets.
// Ports:
//   CLK, RESET_N  - byte clock, async active-low reset
//   DATA_IN/DATA_VALID/DATA_LAST/PKT_TYPE - packet beat input
//   DATA_READY    - beat accepted this cycle (state is DATA)
//   TX_DATA/TX_K  - registered lane symbols and per-lane K flags
//   SKP_ACTIVE    - COM/SKP beat on TX_DATA
//   UNDERRUN      - packet nullified with EDB
module phy_tx_framer
    import phy_symbols_pkg::*;
#(
    parameter int unsigned LANES        = 4,
    parameter int unsigned SKP_INTERVAL = 16,
    parameter int unsigned SKP_LEN      = 3
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [8*LANES-1:0]   DATA_IN,
    input  logic                 DATA_VALID,
    input  logic                 DATA_LAST,
    input  logic                 PKT_TYPE,
    output logic                 DATA_READY,
    output logic [8*LANES-1:0]   TX_DATA,
    output logic [LANES-1:0]     TX_K,
    output logic                 SKP_ACTIVE,
    output logic                 UNDERRUN
);

    localparam int unsigned DW  = 8 * LANES;
    localparam int unsigned SBW = 3;

    framer_state_e  state, state_nxt;
    logic           pkt_type_q, pkt_type_nxt;
    logic [SBW-1:0] skp_beat, skp_beat_nxt;

    logic [DW-1:0]    tx_data_nxt;
    logic [LANES-1:0] tx_k_nxt;
    logic             skp_active_nxt;
    logic             underrun_nxt;
    logic             cnt_en;
    logic             cnt_clr;
    logic             skip_due;

    phy_skp_timer #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .skip_due (skip_due)
    );

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            pkt_type_q <= 1'b0;
            skp_beat   <= '0;
            TX_DATA    <= {LANES{SYM_IDL}};
            TX_K       <= '1;
            SKP_ACTIVE <= 1'b0;
            UNDERRUN   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pkt_type_q <= pkt_type_nxt;
            skp_beat   <= skp_beat_nxt;
            TX_DATA    <= tx_data_nxt;
            TX_K       <= tx_k_nxt;
            SKP_ACTIVE <= skp_active_nxt;
            UNDERRUN   <= underrun_nxt;
        end
    end

    // Next-state logic; a due skip wins over a waiting packet and is only
    // taken from IDLE or END so it never lands inside a packet.
    always_comb begin
        state_nxt    = state;
        pkt_type_nxt = pkt_type_q;
        skp_beat_nxt = skp_beat;
        case (state)
            ST_IDLE: begin
                if (skip_due) begin
                    state_nxt = ST_SKP_COM;
                end else if (DATA_VALID) begin
                    pkt_type_nxt = PKT_TYPE;
                    state_nxt    = ST_START;
                end
            end
            ST_START: state_nxt = ST_DATA;
            ST_DATA: begin
                if (!DATA_VALID) begin
                    state_nxt = ST_IDLE;
                end else if (DATA_LAST) begin
                    state_nxt = ST_END;
                end
            end
            ST_END:     state_nxt = skip_due ? ST_SKP_COM : ST_IDLE;
            ST_SKP_COM: begin
                skp_beat_nxt = SBW'(1);
                state_nxt    = ST_SKP;
            end
            ST_SKP: begin
                if (skp_beat == SBW'(SKP_LEN)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    skp_beat_nxt = skp_beat + SBW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Symbol selection for the current state, registered on the next edge.
    always_comb begin
        tx_data_nxt    = {LANES{SYM_IDL}};
        tx_k_nxt       = '1;
        skp_active_nxt = 1'b0;
        underrun_nxt   = 1'b0;
        cnt_en         = 1'b0;
        cnt_clr        = 1'b0;
        case (state)
            ST_IDLE: cnt_en = 1'b1;
            ST_START: begin
                cnt_en      = 1'b1;
                tx_data_nxt = pkt_type_q ? {LANES{SYM_SDP}} : {LANES{SYM_STP}};
            end
            ST_DATA: begin
                cnt_en = 1'b1;
                if (DATA_VALID) begin
                    tx_data_nxt = DATA_IN;
                    tx_k_nxt    = '0;
                end else begin
                    tx_data_nxt  = {LANES{SYM_EDB}};
                    underrun_nxt = 1'b1;
                end
            end
            ST_END: begin
                cnt_en      = 1'b1;
                tx_data_nxt = {LANES{SYM_END}};
            end
            ST_SKP_COM: begin
                cnt_clr        = 1'b1;
                skp_active_nxt = 1'b1;
                tx_data_nxt    = {LANES{SYM_COM}};
            end
            ST_SKP: begin
                skp_active_nxt = 1'b1;
                tx_data_nxt    = {LANES{SYM_SKP}};
            end
            default: ;
        endcase
    end

    assign DATA_READY = (state == ST_DATA);

endmodule
